// File: rtl/pzvip_gpio_ctrl.sv
// Purpose : two-requester GPIO controller; masked writes with hold time, and
//           masked polls of the input pins with optional timeout.
// Latency : write updates the pins on the accept edge; response follows
//           count+1 cycles later. Poll responds the cycle after a match/timeout.
// Backpr. : req_ready only in IDLE for the granted requester. The response is
//           held stable until rsp_ready of the granted requester.
//
// Ports:
//   clk, reset          - single clock, asynchronous active-high reset
//   req_valid/req_ready - per-requester command handshake (2 requesters)
//   req_poll            - per-requester opcode: 0 = write, 1 = poll
//   req_mask/data/oe    - per-requester WIDTH-bit slices [i*WIDTH +: WIDTH]
//   req_count           - per-requester COUNT_W-bit hold (write) / timeout (poll)
//   rsp_valid/rsp_ready - per-requester completion handshake
//   rsp_timeout         - qualifies rsp_valid: 1 = poll timed out
//   gpio_value_out      - driven pin values
//   gpio_output_enable  - per-pin drive enable
//   gpio_value_in       - pin values, asynchronous to clk
//
// Build option: define PZVIP_GPIO_CTRL_SYNC_EN to pass gpio_value_in through a
// 2-flop synchronizer before the poll compare (adds 2 cycles of pin latency).
// Without it the compare uses gpio_value_in directly.

module pzvip_gpio_ctrl #(
  parameter int WIDTH   = 32,
  parameter int COUNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [1:0]           req_poll,
  input  logic [2*WIDTH-1:0]   req_mask,
  input  logic [2*WIDTH-1:0]   req_data,
  input  logic [2*WIDTH-1:0]   req_oe,
  input  logic [2*COUNT_W-1:0] req_count,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic                 rsp_timeout,
  output logic [WIDTH-1:0]     gpio_value_out,
  output logic [WIDTH-1:0]     gpio_output_enable,
  input  logic [WIDTH-1:0]     gpio_value_in
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    POLL = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

  state_t             state;
  logic               ptr;       // requester with priority at the next grant
  logic               gnt;       // requester owning the command in flight
  logic [WIDTH-1:0]   cmd_mask;
  logic [WIDTH-1:0]   cmd_data;
  logic [COUNT_W-1:0] cnt;
  logic               poll_inf;  // poll issued with count 0: never times out

  // ---------------------------------------------------------------------------
  // Pin sampling
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] in_s;

`ifdef PZVIP_GPIO_CTRL_SYNC_EN
  logic [WIDTH-1:0] sync_q1;
  logic [WIDTH-1:0] sync_q2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= gpio_value_in;
      sync_q2 <= sync_q1;
    end
  end

  assign in_s = sync_q2;
`else
  assign in_s = gpio_value_in;
`endif

  // ---------------------------------------------------------------------------
  // Arbitration: the pointer requester wins if valid, otherwise the other one.
  // ---------------------------------------------------------------------------
  logic               sel;
  logic               sel_vld;
  logic [1:0]         sel_oh;
  logic               sel_poll;
  logic [WIDTH-1:0]   sel_mask;
  logic [WIDTH-1:0]   sel_data;
  logic [WIDTH-1:0]   sel_oe;
  logic [COUNT_W-1:0] sel_count;

  always_comb begin
    sel = ptr;
    if (!req_valid[ptr]) begin
      sel = ~ptr;
    end
  end

  assign sel_vld   = |req_valid;
  assign sel_oh    = sel ? 2'b10 : 2'b01;
  assign sel_poll  = sel ? req_poll[1] : req_poll[0];
  assign sel_mask  = sel ? req_mask[WIDTH +: WIDTH]      : req_mask[0 +: WIDTH];
  assign sel_data  = sel ? req_data[WIDTH +: WIDTH]      : req_data[0 +: WIDTH];
  assign sel_oe    = sel ? req_oe[WIDTH +: WIDTH]        : req_oe[0 +: WIDTH];
  assign sel_count = sel ? req_count[COUNT_W +: COUNT_W] : req_count[0 +: COUNT_W];

  // Accept is combinational in IDLE; forced low while reset is asserted so
  // nothing can be granted before the first edge after release.
  assign req_ready = (state == IDLE && sel_vld && !reset) ? sel_oh : 2'b00;

  logic [1:0] gnt_oh;
  assign gnt_oh = gnt ? 2'b10 : 2'b01;

  // Masked equality: bits outside the mask never block a match, so mask = 0
  // matches on the first compare.
  logic poll_match;
  assign poll_match = ((in_s ^ cmd_data) & cmd_mask) == '0;

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // cnt only ever loads a COUNT_W-bit value and decrements while above one, so
  // it cannot wrap in either direction.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      ptr                <= 1'b0;
      gnt                <= 1'b0;
      cmd_mask           <= '0;
      cmd_data           <= '0;
      cnt                <= '0;
      poll_inf           <= 1'b0;
      rsp_valid          <= 2'b00;
      rsp_timeout        <= 1'b0;
      gpio_value_out     <= '0;
      gpio_output_enable <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sel_vld) begin
            gnt      <= sel;
            cmd_mask <= sel_mask;
            cmd_data <= sel_data;
            cnt      <= sel_count;
            poll_inf <= (sel_count == '0);
            if (sel_poll) begin
              state <= POLL;
            end else begin
              gpio_value_out     <= (gpio_value_out & ~sel_mask) | (sel_data & sel_mask);
              gpio_output_enable <= (gpio_output_enable & ~sel_mask) | (sel_oe & sel_mask);
              if (sel_count != '0) begin
                state <= HOLD;
              end else begin
                state       <= RESP;
                rsp_valid   <= sel_oh;
                rsp_timeout <= 1'b0;
              end
            end
          end
        end

        // Entered with cnt = hold count; leaves after exactly that many cycles.
        HOLD: begin
          if (cnt <= CNT_ONE) begin
            state       <= RESP;
            rsp_valid   <= gnt_oh;
            rsp_timeout <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        // A match is checked first so that it wins on the final timed cycle.
        POLL: begin
          if (poll_match) begin
            state       <= RESP;
            rsp_valid   <= gnt_oh;
            rsp_timeout <= 1'b0;
          end else if (!poll_inf) begin
            if (cnt <= CNT_ONE) begin
              state       <= RESP;
              rsp_valid   <= gnt_oh;
              rsp_timeout <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end

        // Only the owner's rsp_ready is looked at. Returning to IDLE (rather
        // than granting here) keeps a one-cycle gap before the next accept.
        RESP: begin
          if (rsp_ready[gnt]) begin
            state       <= IDLE;
            ptr         <= ~gnt;
            rsp_valid   <= 2'b00;
            rsp_timeout <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pzvip_gpio_ctrl.sv
// Bench for pzvip_gpio_ctrl: directed commands push expected responses into a
// scoreboard queue; a negedge monitor pops and compares on each completion.
module tb_pzvip_gpio_ctrl;

  localparam int W  = 32;
  localparam int CW = 16;
`ifdef PZVIP_GPIO_CTRL_SYNC_EN
  localparam int SYNC_LAT = 2;
  localparam bit SYNC     = 1'b1;
`else
  localparam int SYNC_LAT = 0;
  localparam bit SYNC     = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0]      req_poll;
  logic [2*W-1:0]  req_mask;
  logic [2*W-1:0]  req_data;
  logic [2*W-1:0]  req_oe;
  logic [2*CW-1:0] req_count;
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready;
  logic            rsp_timeout;
  logic [W-1:0]    gpio_value_out;
  logic [W-1:0]    gpio_output_enable;
  logic [W-1:0]    gpio_value_in;

  pzvip_gpio_ctrl #(.WIDTH(W), .COUNT_W(CW)) dut (
    .clk                (clk),
    .reset              (reset),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_poll           (req_poll),
    .req_mask           (req_mask),
    .req_data           (req_data),
    .req_oe             (req_oe),
    .req_count          (req_count),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_timeout        (rsp_timeout),
    .gpio_value_out     (gpio_value_out),
    .gpio_output_enable (gpio_output_enable),
    .gpio_value_in      (gpio_value_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         r;
    bit         to;
    int         acc_cyc;
    int         lat;
    logic [W-1:0] val;
    logic [W-1:0] oe;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] val_m;
  logic [W-1:0] oe_m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drive one command on requester r and wait (bounded) for its accept edge.
  // Returns just after the accept edge.
  task automatic issue(input int r, input bit poll, input logic [W-1:0] mask,
                       input logic [W-1:0] data, input logic [W-1:0] oe,
                       input logic [CW-1:0] count, input bit push,
                       input bit exp_to, input int exp_lat, output int waited);
    bit   ok;
    exp_t e;
    req_poll[r]             = poll;
    req_mask[r*W +: W]      = mask;
    req_data[r*W +: W]      = data;
    req_oe[r*W +: W]        = oe;
    req_count[r*CW +: CW]   = count;
    req_valid[r]            = 1'b1;
    ok = 1'b0;
    waited = 0;
    while (!ok && waited < 50) begin
      #1;
      if (req_ready[r]) ok = 1'b1;
      else begin
        waited++;
        @(negedge clk);
      end
    end
    check("accept", ok, 1);
    if (!ok) begin
      req_valid[r] = 1'b0;
      return;
    end
    check("req_ready_onehot", req_ready, r ? 2'b10 : 2'b01);
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
    if (!poll) begin
      val_m = (val_m & ~mask) | (data & mask);
      oe_m  = (oe_m & ~mask) | (oe & mask);
      check("write_value_out", gpio_value_out, val_m);
      check("write_oe", gpio_output_enable, oe_m);
    end
    if (push) begin
      e.r = r; e.to = exp_to; e.acc_cyc = cyc; e.lat = exp_lat;
      e.val = val_m; e.oe = oe_m;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && rsp_valid == 2'b00) done = 1'b1;
    end
    check("drain", done, 1);
  endtask

  // Monitor: latency is measured from the first cycle rsp_valid is seen.
  bit         in_rsp = 1'b0;
  int         first_cyc;
  logic [1:0] held_v;
  logic       held_to;

  always @(negedge clk) begin
    if (reset) begin
      in_rsp = 1'b0;
    end else if (|rsp_valid) begin
      if (!in_rsp) begin
        in_rsp    = 1'b1;
        first_cyc = cyc;
        held_v    = rsp_valid;
        held_to   = rsp_timeout;
      end else begin
        check("rsp_valid_stable", rsp_valid, held_v);
        check("rsp_timeout_stable", rsp_timeout, held_to);
      end
      if (|(rsp_valid & rsp_ready)) begin
        in_rsp = 1'b0;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp actual=%0h required=none", rsp_valid);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_requester", rsp_valid, e.r ? 2'b10 : 2'b01);
          check("rsp_timeout", rsp_timeout, e.to);
          check("rsp_latency", first_cyc - e.acc_cyc + 1, e.lat);
          check("rsp_value_out", gpio_value_out, e.val);
          check("rsp_oe", gpio_output_enable, e.oe);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  w;
    int  n;
    bit  last;
    bit  seen;
    exp_t e;

    reset = 1'b1; req_valid = 2'b00; req_poll = 2'b00;
    req_mask = '0; req_data = '0; req_oe = '0; req_count = '0;
    rsp_ready = 2'b11; gpio_value_in = '0;
    val_m = '0; oe_m = '0;

    // Reset state, with both requesters asking.
    repeat (2) @(negedge clk);
    req_valid = 2'b11;
    #1;
    check("reset_req_ready", req_ready, 2'b00);
    check("reset_rsp_valid", rsp_valid, 2'b00);
    check("reset_rsp_timeout", rsp_timeout, 0);
    check("reset_value_out", gpio_value_out, 0);
    check("reset_oe", gpio_output_enable, 0);
    req_valid = 2'b00;
    @(negedge clk);
    reset = 1'b0;

    // Arbitration: both always valid -> grants 0,1,0,1.
    // req0: write with mask 0 (no pin change), req1: poll with mask 0.
    req_poll  = 2'b10;
    req_mask  = '0;
    req_data  = {32'h1234_5678, 32'hFFFF_FFFF};
    req_oe    = {32'h0, 32'hFFFF_FFFF};
    req_count = '0;
    req_valid = 2'b11;
    n = 0; last = 1'b0;
    for (int i = 0; i < 100 && n < 4; i++) begin
      #1;
      if (|req_ready) begin
        check("arb_grant", req_ready, n[0] ? 2'b10 : 2'b01);
        if (n > 0) check("arb_no_repeat", req_ready[1], !last);
        last = req_ready[1];
        @(posedge clk);
        #1;
        e.r = last; e.to = 1'b0; e.acc_cyc = cyc; e.lat = last ? 2 : 1;
        e.val = val_m; e.oe = oe_m;
        sb.push_back(e);
        n++;
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    check("arb_grants", n, 4);
    drain();

    // Masked write, count 0.
    issue(0, 1'b0, 32'h0000_00FF, 32'hFFFF_FFA5, 32'hFFFF_FFFF, 16'd0, 1'b1, 1'b0, 1, w);
    check("masked_write_value", gpio_value_out, 32'h0000_00A5);
    check("masked_write_oe", gpio_output_enable, 32'h0000_00FF);
    drain();

    // Hold count 3 -> response 4 cycles after accept.
    issue(1, 1'b0, 32'h0000_0F00, 32'h0000_0300, 32'h0000_0F00, 16'd3, 1'b1, 1'b0, 4, w);
    drain();

    // Requester 1 pulses valid during a hold and withdraws: never accepted.
    @(negedge clk);
    issue(0, 1'b0, 32'h0000_F000, 32'h0000_5000, 32'h0000_F000, 16'd4, 1'b1, 1'b0, 5, w);
    req_poll[1] = 1'b0;
    req_mask[W +: W] = 32'hFFFF_FFFF;
    req_count[CW +: CW] = '0;
    req_valid[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("withdrawn_not_ready", req_ready, 2'b00);
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    drain();
    check("withdrawn_no_write", gpio_value_out, 32'h0000_53A5);

    // Poll success: pin rises in POLL cycle 4.
    @(negedge clk);
    issue(0, 1'b1, 32'h1, 32'h1, 32'h0, 16'd10, 1'b1, 1'b0, 5 + SYNC_LAT, w);
    repeat (3) @(posedge clk);
    #1 gpio_value_in = 32'h1;
    drain();
    gpio_value_in = '0;
    repeat (4) @(negedge clk);

    // Pin rises in the final timed cycle: match wins (only when unsynchronised).
    issue(1, 1'b1, 32'h1, 32'h1, 32'h0, 16'd5, 1'b1, SYNC, 6, w);
    repeat (4) @(posedge clk);
    #1 gpio_value_in = 32'h1;
    drain();
    gpio_value_in = '0;
    repeat (4) @(negedge clk);

    // Poll timeout with backpressure; the other requester's ready is ignored.
    rsp_ready = 2'b10;
    issue(0, 1'b1, 32'h1, 32'h1, 32'h0, 16'd5, 1'b1, 1'b1, 6, w);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid[0]) seen = 1'b1;
    end
    check("timeout_rsp_seen", seen, 1);
    repeat (3) @(negedge clk);
    check("timeout_rsp_held", rsp_valid, 2'b01);
    check("timeout_flag_held", rsp_timeout, 1);
    @(posedge clk);
    #1 rsp_ready = 2'b11;
    drain();

    // Mask 0 poll matches on its first POLL cycle.
    issue(1, 1'b1, 32'h0, 32'hDEAD_BEEF, 32'h0, 16'd0, 1'b1, 1'b0, 2, w);
    drain();

    // Reset during an endless poll: no response, pins cleared at once.
    issue(0, 1'b1, 32'h1, 32'h1, 32'h0, 16'd0, 1'b0, 1'b0, 0, w);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("midreset_value_out", gpio_value_out, 0);
    check("midreset_oe", gpio_output_enable, 0);
    check("midreset_rsp_valid", rsp_valid, 2'b00);
    val_m = '0; oe_m = '0;
    req_valid[0] = 1'b1;
    #1;
    check("midreset_req_ready", req_ready, 2'b00);
    repeat (2) @(negedge clk);
    check("midreset_rsp_valid_later", rsp_valid, 2'b00);
    reset = 1'b0;
    issue(0, 1'b0, 32'h0000_00FF, 32'h0000_003C, 32'h0000_00FF, 16'd0, 1'b1, 1'b0, 1, w);
    check("first_edge_accept_wait", w, 0);
    check("post_reset_value_out", gpio_value_out, 32'h0000_003C);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
